// File: rtl/sbio_receiver.sv
// sbio_receiver - deserializer stage downstream of the serial-bus IO monitor.
//
// Assembles IO_BITS-per-cycle data (LSB-first) into a MSG_BITS word. The
// message framing comes from the monitor's start/active/counter outputs.
// The completed word is handed to the core through a single-entry
// valid/ready buffer.
//
// Optional feature macro: SBIO_RX_PARITY_EN
//   When defined, each message has one extra cycle (counter == NUM_CYCLES).
//   pins[0] in that cycle is an even-parity bit over the payload, and
//   parity_err is registered with rx_data. When undefined, parity_err is 0.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   pins       in   serial bus pins (IO_BITS), same signal that feeds the monitor
//   start      in   monitor start strobe (start-bit cycle)
//   active     in   monitor active flag
//   counter    in   monitor cycle counter (COUNTER_BITS)
//   done       out  to monitor; high during the last cycle of a message
//   rx_data    out  last completed message word (MSG_BITS)
//   rx_valid   out  rx_data holds an unconsumed word
//   rx_ready   in   consumer accepts rx_data when rx_valid && rx_ready
//   overflow   out  sticky: a completed message was dropped
//   parity_err out  parity error flag for rx_data
module sbio_receiver #(
  parameter int IO_BITS                = 2,
  parameter int SENS_BITS              = 2,
  parameter int COUNTER_BITS           = 5,
  parameter int INACTIVE_COUNTER_VALUE = 31,
  parameter int MSG_BITS               = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IO_BITS-1:0]      pins,
  input  logic                    start,
  input  logic                    active,
  input  logic [COUNTER_BITS-1:0] counter,
  output logic                    done,
  output logic [MSG_BITS-1:0]     rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    overflow,
  output logic                    parity_err
);

  localparam int NUM_CYCLES = MSG_BITS / IO_BITS;
`ifdef SBIO_RX_PARITY_EN
  localparam int LAST = NUM_CYCLES;
`else
  localparam int LAST = NUM_CYCLES - 1;
`endif
  localparam logic [COUNTER_BITS-1:0] LAST_CNT = COUNTER_BITS'(LAST);

  // Elaboration-time sanity checks on the monitor pairing.
  if (INACTIVE_COUNTER_VALUE != (2 ** COUNTER_BITS) - 1) begin : g_bad_idle
    $error("INACTIVE_COUNTER_VALUE must equal 2^COUNTER_BITS-1");
  end
  if ((MSG_BITS % IO_BITS) != 0 || NUM_CYCLES >= INACTIVE_COUNTER_VALUE) begin : g_bad_len
    $error("MSG_BITS must be a multiple of IO_BITS with NUM_CYCLES below the idle value");
  end
  if (SENS_BITS > IO_BITS) begin : g_bad_sens
    $error("SENS_BITS must not exceed IO_BITS");
  end

  logic [MSG_BITS-1:0] shift_q, shift_d;
  logic [MSG_BITS-1:0] word_d;
  logic [MSG_BITS-1:0] rx_data_q;
  logic                rx_valid_q;
  logic                overflow_q;
  logic                parity_err_q;
  logic                parity_err_d;

  // word_d is the shift register with the current cycle's pins merged in, so
  // the commit on the done edge includes the last data cycle.
  always_comb begin
    word_d = shift_q;
    if (active) begin
      for (int unsigned k = 0; k < NUM_CYCLES; k++) begin
        if (counter == COUNTER_BITS'(k)) begin
          word_d[IO_BITS*k +: IO_BITS] = pins;
        end
      end
    end
    shift_d = start ? '0 : word_d;
  end

  always_comb begin
    done = active && (counter == LAST_CNT) && !reset;
  end

`ifdef SBIO_RX_PARITY_EN
  always_comb begin
    parity_err_d = (^word_d) ^ pins[0];
  end
`else
  always_comb begin
    parity_err_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      if (done) begin
        // A consume in the same cycle frees the buffer for the new word.
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= word_d;
          rx_valid_q   <= 1'b1;
          parity_err_q <= parity_err_d;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;

endmodule

// File: doc/sbio_receiver.md
Name: sbio_receiver

Overview:
- Deserializer stage directly downstream of the serial-bus IO monitor.
- Consumes the monitor's start/active/counter outputs and the raw pins, and assembles each message into a MSG_BITS word.
- Drives the monitor's done input on the last message cycle.
- Presents the completed word on a single-entry valid/ready output buffer to the core.

Parameters:
- IO_BITS, 2, pin width, i.e. bits received per cycle
- SENS_BITS, 2, low pins that signal a start bit; must match the monitor
- COUNTER_BITS, 5, monitor counter width
- INACTIVE_COUNTER_VALUE, 31, monitor idle counter value; must equal 2^COUNTER_BITS-1 so that the first data cycle reads counter=0
- MSG_BITS, 16, payload bits per message; must be a multiple of IO_BITS
- NUM_CYCLES (localparam), MSG_BITS/IO_BITS, data cycles per message; must be below INACTIVE_COUNTER_VALUE

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pins  in  IO_BITS  serial bus pins, same signal that feeds the monitor
- start  in  1  monitor start strobe (start-bit cycle)
- active  in  1  monitor active flag
- counter  in  COUNTER_BITS  monitor cycle counter
- done  out  1  to monitor; high during the last cycle of a message
- rx_data  out  MSG_BITS  last completed message word
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
- overflow  out  1  sticky flag: a completed message was dropped
- parity_err  out  1  parity error flag for rx_data (see Optional Feature)

Behaviour:
- Reset values: rx_valid=0, rx_data=0, overflow=0, parity_err=0, shift register=0. done is forced to 0 while reset is high.
- Start-bit cycle: the pins value is ignored beyond start detection, which the monitor performs. The shift register is cleared on start.
- Data cycles:
  - Each cycle with active=1 and counter=k (0 ≤ k < NUM_CYCLES) writes pins into shift bits [IO_BITS*k +: IO_BITS]. Data is LSB-first.
  - Cycles with counter ≥ NUM_CYCLES are never written.
- Last cycle:
  - done = active && counter==LAST && !reset, where LAST = NUM_CYCLES-1, or NUM_CYCLES when parity is enabled.
  - done is combinational, so the monitor returns to idle on the next edge.
  - The completed word (including the pins sampled that same cycle) is committed at that edge.
- Commit rules, evaluated at the done edge:
  - Buffer empty (rx_valid=0), or buffer being consumed this cycle (rx_valid && rx_ready): rx_data <= word, rx_valid <= 1.
  - Buffer full and not consumed: the word is dropped, rx_data is unchanged, and overflow <= 1.
- Consume without commit: rx_valid && rx_ready clears rx_valid at the next edge. rx_data holds its value.
- Latency: rx_valid rises on the edge after the done cycle, i.e. NUM_CYCLES+1 cycles after the start-bit cycle (parity disabled).
- Back-to-back messages: a start on the cycle after done is accepted. The shift register is cleared on that start cycle.
- Reset mid-message: the partial word is discarded and no commit occurs. The monitor is reset by the same signal.
- overflow clears only on reset.

Optional Feature:
- Macro: SBIO_RX_PARITY_EN.
- Enabled:
  - Each message carries one extra cycle at counter=NUM_CYCLES. pins[0] of that cycle is the even-parity bit over the MSG_BITS payload; other pins in that cycle are ignored.
  - done moves to that cycle.
  - parity_err is registered alongside rx_data at commit: 1 if XOR(payload, parity bit) ≠ 0.
  - The word is still delivered when parity_err=1.
- Disabled: message length is NUM_CYCLES, and parity_err is constant 0.

Test Plan:
- Single message (defaults, parity off): pins=01 at cycle T, then pins=0,1,2,3,0,1,2,3 on T+1..T+8 -> done=1 only at T+8 (counter=7); rx_valid=1 at T+9; rx_data=16'hE4E4; overflow=0.
- Held buffer: with rx_ready=0, send 16'hE4E4, then a second message with all pins=3 -> rx_data stays 16'hE4E4, rx_valid stays 1, overflow=1 after the second done edge.
- Simultaneous consume and commit: rx_ready=1 exactly during the second message's done cycle -> rx_data=16'hFFFF, rx_valid remains 1, overflow=0.
- Back-to-back: a start immediately after done, with payload 16'h0001 (pins=1 then seven 0s) -> second word 16'h0001 correct, with no residue from the first word.
- Reset mid-message: assert reset for 1 cycle at counter=3 -> rx_valid=0, no commit. The next full message 16'hE4E4 is received correctly.
- Parity (SBIO_RX_PARITY_EN): payload 16'hE4E4 (8 ones), parity pin 0 -> done at counter=8, parity_err=0. Same payload with parity pin 1 -> parity_err=1 and rx_data=16'hE4E4.
